// File: rtl/alu_pkg.sv
// alu_pkg: shared op/state encodings and helpers
// for the registered Hack ALU.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_HACK = 2'b00,
    OP_MUL  = 2'b01,
    OP_SHL  = 2'b10,
    OP_SAR  = 2'b11
  } op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  function automatic int log2w(input int w);
    int n;
    n = 0;
    while ((1 << n) < w) n++;
    return n;
  endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational WIDTH-bit Hack ALU with
// adder carry and signed overflow.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  output logic [WIDTH-1:0] px,
  output logic [WIDTH-1:0] py,
  output logic [WIDTH-1:0] r,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH:0] sum;

  assign px = (zx ? '0 : x) ^ {WIDTH{nx}};
  assign py = (zy ? '0 : y) ^ {WIDTH{ny}};
  assign sum = {1'b0, px} + {1'b0, py};

  assign carry = f & sum[WIDTH];
  assign overflow = f
    & (px[WIDTH-1] == py[WIDTH-1])
    & (sum[WIDTH-1] != px[WIDTH-1]);

  assign r = (f ? sum[WIDTH-1:0] : (px & py))
    ^ {WIDTH{no}};

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered Hack ALU with shift-add multiplier,
// barrel shifter, flags and valid/ready handshake.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             cy,
  output logic             ov,
  output logic             busy
);

  localparam int LW = log2w(WIDTH);

  state_t             state;
  logic [WIDTH-1:0]   px, py, hack_r;
  logic               hack_cy, hack_ov;
  logic [2*WIDTH-1:0] acc, mcand, acc_nx;
  logic [WIDTH-1:0]   mplier, mul_r;
  logic [LW-1:0]      cnt;
  logic               no_q, mul_ov;
  logic               accept, sat;
  logic [LW-1:0]      amt;
  logic [WIDTH-1:0]   res;
  logic               res_cy, res_ov;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .x(x), .y(y),
    .zx(zx), .nx(nx), .zy(zy), .ny(ny),
    .f(f), .no(no),
    .px(px), .py(py), .r(hack_r),
    .carry(hack_cy), .overflow(hack_ov)
  );

  assign in_ready = reset_n
    & (state == ST_IDLE)
    & (!out_valid | out_ready);
  assign accept = in_valid & in_ready;

  assign amt = py[LW-1:0];
  assign sat = |py[WIDTH-1:LW];

  assign acc_nx = mplier[0] ? acc + mcand : acc;
  assign mul_r  = acc_nx[WIDTH-1:0] ^ {WIDTH{no_q}};
  assign mul_ov = |acc_nx[2*WIDTH-1:WIDTH];

  always_comb begin
    res    = '0;
    res_cy = 1'b0;
    res_ov = 1'b0;
    unique case (op_t'(op))
      OP_HACK: begin
        res    = hack_r;
        res_cy = hack_cy;
        res_ov = hack_ov;
      end
      OP_SHL:
        res = (sat ? '0 : (px << amt))
          ^ {WIDTH{no}};
      OP_SAR:
        res = (sat ? {WIDTH{px[WIDTH-1]}}
          : WIDTH'($signed(px) >>> amt))
          ^ {WIDTH{no}};
      OP_MUL:
        res_ov = 1'b1;
      default: res = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      out       <= '0;
      zr        <= 1'b0;
      ng        <= 1'b0;
      cy        <= 1'b0;
      ov        <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      no_q      <= 1'b0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            if (MUL_EN && op == OP_MUL) begin
              mcand  <= {{WIDTH{1'b0}}, px};
              mplier <= py;
              acc    <= '0;
              cnt    <= '0;
              no_q   <= no;
              busy   <= 1'b1;
              state  <= ST_MUL;
            end else begin
              out       <= res;
              zr        <= (res == '0);
              ng        <= res[WIDTH-1];
              cy        <= res_cy;
              ov        <= res_ov;
              out_valid <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          acc    <= acc_nx;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          // last multiplier bit: publish the product
          if (cnt == LW'(WIDTH-1)) begin
            out       <= mul_r;
            zr        <= (mul_r == '0);
            ng        <= mul_r[WIDTH-1];
            cy        <= 1'b0;
            ov        <= mul_ov;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq
// using immediate assertions.
module tb_alu_seq;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [15:0] x, y;
  logic        zx, nx, zy, ny, f, no;
  logic [1:0]  op;
  logic        out_valid, out_ready;
  logic [15:0] out;
  logic        zr, ng, cy, ov, busy;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  alu_seq #(.WIDTH(16), .MUL_EN(1'b1)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y),
    .zx(zx), .nx(nx), .zy(zy), .ny(ny),
    .f(f), .no(no), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zr(zr), .ng(ng), .cy(cy), .ov(ov),
    .busy(busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [15:0] xv,
                       input logic [15:0] yv,
                       input logic [5:0]  c,
                       input logic [1:0]  o);
    x = xv;
    y = yv;
    {zx, nx, zy, ny, f, no} = c;
    op = o;
    in_valid = 1'b1;
  endtask

  initial begin
    logic bad;
    reset_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    x = '0; y = '0; op = '0;
    {zx, nx, zy, ny, f, no} = '0;
    repeat (2) @(negedge clock);
    chk("rst_out", out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_flags", {zr, ng, cy, ov}, 0);

    reset_n = 1'b1;
    #1 chk("rel_ready", in_ready, 1);

    // add 5+7
    drive(16'd5, 16'd7, 6'b000010, 2'b00);
    @(negedge clock);
    chk("add_out", out, 16'd12);
    chk("add_flags", {zr, ng, cy, ov}, 4'b0000);
    chk("add_valid", out_valid, 1);

    // x-1 with x=0x8000
    drive(16'h8000, 16'h1234, 6'b001110, 2'b00);
    @(negedge clock);
    chk("dec_out", out, 16'h7FFF);
    chk("dec_flags", {zr, ng, cy, ov}, 4'b0011);

    // !x
    drive(16'h00FF, 16'h5555, 6'b001101, 2'b00);
    @(negedge clock);
    chk("notx_out", out, 16'hFF00);
    chk("notx_flags", {zr, ng, cy, ov}, 4'b0100);

    drive(16'h8000, 16'd4, 6'b000000, 2'b11);
    @(negedge clock);
    chk("sar4", out, 16'hF800);
    chk("sar4_ng", ng, 1);

    drive(16'h8000, 16'd20, 6'b000000, 2'b11);
    @(negedge clock);
    chk("sar20", out, 16'hFFFF);

    drive(16'h0001, 16'd16, 6'b000000, 2'b10);
    @(negedge clock);
    chk("shl16", out, 16'h0000);
    chk("shl16_zr", zr, 1);

    drive(16'h0001, 16'd3, 6'b000000, 2'b10);
    @(negedge clock);
    chk("shl3", out, 16'h0008);

    // multiply 300*300
    drive(16'd300, 16'd300, 6'b000000, 2'b01);
    @(negedge clock);
    in_valid = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (out_valid !== 1'b0 || busy !== 1'b1 ||
          in_ready !== 1'b0)
        bad = 1'b1;
      @(negedge clock);
    end
    chk("mul_wait", bad, 0);
    chk("mul_valid", out_valid, 1);
    chk("mul_out", out, 16'h5F90);
    chk("mul_ov", ov, 1);
    chk("mul_busy", busy, 0);

    @(negedge clock);
    chk("consume", out_valid, 0);

    // backpressure
    out_ready = 1'b0;
    drive(16'd1, 16'd2, 6'b000010, 2'b00);
    @(negedge clock);
    chk("bp_first", out, 16'd3);
    drive(16'd10, 16'd4, 6'b000010, 2'b00);
    #1 chk("bp_ready", in_ready, 0);
    @(negedge clock);
    chk("bp_hold", out, 16'd3);
    chk("bp_valid", out_valid, 1);
    out_ready = 1'b1;
    #1 chk("bp_ready2", in_ready, 1);
    @(negedge clock);
    chk("bp_second", out, 16'd14);
    chk("bp_valid2", out_valid, 1);
    in_valid = 1'b0;
    @(negedge clock);
    chk("bp_drain", {out_valid, out}, {1'b0, 16'd14});

    // reset in the middle of a multiply
    drive(16'd3, 16'd5, 6'b000000, 2'b01);
    @(negedge clock);
    in_valid = 1'b0;
    repeat (4) @(negedge clock);
    chk("mid_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_out", out, 0);
    @(negedge clock);
    reset_n = 1'b1;
    #1 chk("mrst_ready", in_ready, 1);
    drive(16'd9, 16'd6, 6'b000010, 2'b00);
    @(negedge clock);
    in_valid = 1'b0;
    chk("post_out", out, 16'd15);
    chk("post_valid", out_valid, 1);
    repeat (20) @(negedge clock);
    chk("no_stray", {out_valid, busy}, 2'b00);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
